// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter: mode-FSM encodings,
// read-return owner codes and the owner register layout.
package mem_port_arbiter_pkg;

    // Mode FSM: RUN arbitrates normally, DRAIN lets one read response land,
    // LOAD gives the RAM to the loader only.
    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_DRAIN = 2'd1,
        MODE_LOAD  = 2'd2
    } mode_e;

    // Which port a RAM access was granted to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LD   = 2'd2
    } owner_e;

    // Registered record of last cycle's grant, used to route read data.
    typedef struct packed {
        logic   rd;
        owner_e owner;
    } owner_t;

    // Bits needed to hold a count of 0..limit.
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating counter of consecutive CPU wins while the loader waits.
// Clear has priority over increment. at_limit tells the arbiter to let
// the loader in on the current cycle.
module arb_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = 4,
    parameter int W     = cnt_width(LIMIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [W-1:0] cnt_q;

    // Count up on each starved cycle, stop at LIMIT, drop to zero on clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != W'(LIMIT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign at_limit = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port data RAM shared by the CPU datapath and the
// UART loader/debug port. The CPU has fixed priority. A starvation counter
// forces one loader slot after STARVE_LIMIT CPU wins. load_mode hands the
// RAM to the loader exclusively. The CPU is stalled while load_mode is set.
//
// Handshake: a requester raises *_req with its we/addr/wdata and holds all
// of them stable. A cycle with the grant (cpu_stall=0 for the CPU, ld_ack=1
// for the loader) is the cycle the access happens. After that cycle the
// requester may change or drop the request. A granted read returns one
// cycle later as a single *_rvalid pulse with *_rdata. Between pulses
// *_rdata keeps the last value returned to that port.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_mode,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        mode
);

    mode_e             state_q;
    owner_t            owner_q;
    logic [DATA_W-1:0] cpu_hold_q;
    logic [DATA_W-1:0] ld_hold_q;

    logic cpu_grant;
    logic ld_grant;
    logic rd_issue;
    logic at_limit;
    logic run_arb;
    logic load_arb;

    // Dropping load_mode while in LOAD applies RUN arbitration that same cycle.
    assign run_arb  = (state_q == MODE_RUN) || ((state_q == MODE_LOAD) && !load_mode);
    assign load_arb = (state_q == MODE_LOAD) && load_mode;

    // Pick at most one port per cycle. Nothing is granted while reset is held.
    always_comb begin
        cpu_grant = 1'b0;
        ld_grant  = 1'b0;
        if (!reset) begin
            if (run_arb) begin
                if (cpu_req && !(ld_req && at_limit)) begin
                    cpu_grant = 1'b1;
                end else if (ld_req) begin
                    ld_grant = 1'b1;
                end
            end else if (load_arb) begin
                ld_grant = ld_req;
            end
        end
    end

    assign cpu_stall = cpu_req && !cpu_grant;
    assign ld_ack    = ld_grant;
    assign rd_issue  = (cpu_grant && !cpu_we) || (ld_grant && !ld_we);

    // Drive the RAM from the granted port. Address and data are zero when idle.
    always_comb begin
        mem_en    = cpu_grant || ld_grant;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_grant) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ld_grant) begin
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
    end

    // Count CPU wins while the loader is waiting. Any loader slot or idle loader resets the count.
    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (cpu_grant && ld_req),
        .clr      (ld_grant || !ld_req),
        .at_limit (at_limit)
    );

    // Mode FSM. A read granted on the cycle load_mode is seen goes through DRAIN so its response lands first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MODE_RUN;
        end else begin
            case (state_q)
                MODE_RUN: begin
                    if (load_mode) begin
                        state_q <= rd_issue ? MODE_DRAIN : MODE_LOAD;
                    end
                end
                MODE_DRAIN: begin
                    state_q <= MODE_LOAD;
                end
                MODE_LOAD: begin
                    if (!load_mode) begin
                        state_q <= MODE_RUN;
                    end
                end
                default: begin
                    state_q <= MODE_RUN;
                end
            endcase
        end
    end

    assign mode = state_q;

    // Remember who issued this cycle's read so next cycle's RAM data goes to that port.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= '{rd: 1'b0, owner: OWN_NONE};
        end else begin
            owner_q.rd    <= rd_issue;
            owner_q.owner <= cpu_grant ? OWN_CPU : (ld_grant ? OWN_LD : OWN_NONE);
        end
    end

    // A response that lands while reset is held is discarded.
    assign cpu_rvalid = !reset && owner_q.rd && (owner_q.owner == OWN_CPU);
    assign ld_rvalid  = !reset && owner_q.rd && (owner_q.owner == OWN_LD);

    // Hold each port's last returned word so its rdata stays put between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_hold_q <= '0;
            ld_hold_q  <= '0;
        end else begin
            if (cpu_rvalid) begin
                cpu_hold_q <= mem_rdata;
            end
            if (ld_rvalid) begin
                ld_hold_q <= mem_rdata;
            end
        end
    end

    assign cpu_rdata = reset ? '0 : (cpu_rvalid ? mem_rdata : cpu_hold_q);
    assign ld_rdata  = reset ? '0 : (ld_rvalid  ? mem_rdata : ld_hold_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM.
// Inputs change 1 ns after the rising edge. Outputs are checked on the falling edge.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_mode = 1'b0;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = '0, cpu_wdata = '0;
    logic       cpu_stall, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       ld_req = 1'b0, ld_we = 1'b0;
    logic [7:0] ld_addr = '0, ld_wdata = '0;
    logic       ld_ack, ld_rvalid;
    logic [7:0] ld_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic [1:0] mode;

    logic [7:0] ram [256];
    int total = 0;
    int passed = 0;

    // clock / reset
    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .load_mode(load_mode),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mode(mode)
    );

    // synchronous RAM model, 1-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // driver: start a new cycle and settle inputs after the edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (mem_en !== 1'b0) $display("FAIL rst_mem_en: got %b want 0", mem_en); else passed++;
        total++; if (ld_ack !== 1'b0) $display("FAIL rst_ld_ack: got %b want 0", ld_ack); else passed++;
        total++; if (cpu_stall !== 1'b1) $display("FAIL rst_cpu_stall: got %b want 1", cpu_stall); else passed++;
        total++; if (cpu_rvalid !== 1'b0 || ld_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b%b want 00", cpu_rvalid, ld_rvalid); else passed++;
        total++; if (cpu_rdata !== 8'h00 || ld_rdata !== 8'h00) $display("FAIL rst_rdata: got %h/%h want 00/00", cpu_rdata, ld_rdata); else passed++;
        total++; if (mode !== 2'(MODE_RUN)) $display("FAIL rst_mode: got %0d want %0d", mode, MODE_RUN); else passed++;
        next_cycle();
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        total++; if (cpu_stall !== 1'b0 || mem_en !== 1'b0) $display("FAIL rst_release: stall=%b en=%b want 0/0", cpu_stall, mem_en); else passed++;
    endtask

    task automatic test_cpu_write_read();
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'h5A;
        @(negedge clk);
        total++; if (mem_en !== 1'b1 || mem_we !== 1'b1) $display("FAIL wr_strobe: en=%b we=%b want 1/1", mem_en, mem_we); else passed++;
        total++; if (mem_addr !== 8'h10 || mem_wdata !== 8'h5A) $display("FAIL wr_bus: got %h/%h want 10/5a", mem_addr, mem_wdata); else passed++;
        total++; if (cpu_stall !== 1'b0) $display("FAIL wr_stall: got %b want 0", cpu_stall); else passed++;
        next_cycle();
        cpu_we = 1'b0;
        @(negedge clk);
        total++; if (mem_en !== 1'b1 || mem_we !== 1'b0) $display("FAIL rd_strobe: en=%b we=%b want 1/0", mem_en, mem_we); else passed++;
        total++; if (cpu_stall !== 1'b0) $display("FAIL rd_stall: got %b want 0", cpu_stall); else passed++;
        total++; if (cpu_rvalid !== 1'b0) $display("FAIL wr_no_rvalid: got %b want 0", cpu_rvalid); else passed++;
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A) $display("FAIL rd_return: rvalid=%b data=%h want 1/5a", cpu_rvalid, cpu_rdata); else passed++;
        total++; if (ld_rvalid !== 1'b0) $display("FAIL rd_ld_rvalid: got %b want 0", ld_rvalid); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h5A) $display("FAIL rd_hold: rvalid=%b data=%h want 0/5a", cpu_rvalid, cpu_rdata); else passed++;
    endtask

    task automatic test_starvation();
        logic exp_ld;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'(k); cpu_wdata = 8'(k);
            ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'(8'h80 + k); ld_wdata = 8'hC0;
            @(negedge clk);
            exp_ld = ((k % 5) == 4);
            total++; if (ld_ack !== exp_ld) $display("FAIL starve_ack[%0d]: got %b want %b", k, ld_ack, exp_ld); else passed++;
            total++; if (cpu_stall !== exp_ld) $display("FAIL starve_stall[%0d]: got %b want %b", k, cpu_stall, exp_ld); else passed++;
            total++; if (mem_addr !== (exp_ld ? 8'(8'h80 + k) : 8'(k))) $display("FAIL starve_addr[%0d]: got %h", k, mem_addr); else passed++;
        end
        next_cycle();
        cpu_req = 1'b0; ld_req = 1'b0; cpu_we = 1'b0; ld_we = 1'b0;
    endtask

    task automatic test_load_drain();
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; load_mode = 1'b1;
        @(negedge clk);
        total++; if (cpu_stall !== 1'b0 || mem_en !== 1'b1) $display("FAIL drain_grant: stall=%b en=%b want 0/1", cpu_stall, mem_en); else passed++;
        total++; if (mode !== 2'(MODE_RUN)) $display("FAIL drain_mode0: got %0d want %0d", mode, MODE_RUN); else passed++;
        next_cycle();
        cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h33;
        @(negedge clk);
        total++; if (mode !== 2'(MODE_DRAIN)) $display("FAIL drain_mode1: got %0d want %0d", mode, MODE_DRAIN); else passed++;
        total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A) $display("FAIL drain_rvalid: rvalid=%b data=%h want 1/5a", cpu_rvalid, cpu_rdata); else passed++;
        total++; if (mem_en !== 1'b0 || cpu_stall !== 1'b1) $display("FAIL drain_idle: en=%b stall=%b want 0/1", mem_en, cpu_stall); else passed++;
        next_cycle();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h00; ld_wdata = 8'hFF;
        @(negedge clk);
        total++; if (mode !== 2'(MODE_LOAD)) $display("FAIL load_mode: got %0d want %0d", mode, MODE_LOAD); else passed++;
        total++; if (ld_ack !== 1'b1 || cpu_stall !== 1'b1) $display("FAIL load_ack: ack=%b stall=%b want 1/1", ld_ack, cpu_stall); else passed++;
        total++; if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 8'hFF) $display("FAIL load_bus: we=%b %h/%h want 1 00/ff", mem_we, mem_addr, mem_wdata); else passed++;
        total++; if (cpu_rvalid !== 1'b0) $display("FAIL load_rvalid: got %b want 0", cpu_rvalid); else passed++;
        next_cycle();
        ld_req = 1'b0;
        @(negedge clk);
        total++; if (cpu_stall !== 1'b1 || mem_en !== 1'b0 || ld_ack !== 1'b0) $display("FAIL load_idle: stall=%b en=%b ack=%b want 1/0/0", cpu_stall, mem_en, ld_ack); else passed++;
    endtask

    task automatic test_load_exit();
        next_cycle();
        load_mode = 1'b0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h00;
        @(negedge clk);
        total++; if (ld_ack !== 1'b0 || cpu_stall !== 1'b0) $display("FAIL exit_grant: ack=%b stall=%b want 0/0", ld_ack, cpu_stall); else passed++;
        total++; if (mem_addr !== 8'h20 || mem_wdata !== 8'h33) $display("FAIL exit_bus: got %h/%h want 20/33", mem_addr, mem_wdata); else passed++;
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        total++; if (mode !== 2'(MODE_RUN)) $display("FAIL exit_mode: got %0d want %0d", mode, MODE_RUN); else passed++;
        total++; if (ld_ack !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h00) $display("FAIL exit_ld: ack=%b we=%b addr=%h want 1/0/00", ld_ack, mem_we, mem_addr); else passed++;
        next_cycle();
        ld_req = 1'b0;
        @(negedge clk);
        total++; if (ld_rvalid !== 1'b1 || ld_rdata !== 8'hFF) $display("FAIL exit_rdata: rvalid=%b data=%h want 1/ff", ld_rvalid, ld_rdata); else passed++;
        total++; if (cpu_rvalid !== 1'b0) $display("FAIL exit_cpu_rvalid: got %b want 0", cpu_rvalid); else passed++;
    endtask

    task automatic test_reset_mid();
        next_cycle();
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h20;
        @(negedge clk);
        total++; if (ld_ack !== 1'b1) $display("FAIL mid_ld_ack: got %b want 1", ld_ack); else passed++;
        next_cycle();
        reset = 1'b1; ld_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h77;
        @(negedge clk);
        total++; if (ld_rvalid !== 1'b0) $display("FAIL mid_ld_rvalid: got %b want 0", ld_rvalid); else passed++;
        total++; if (ld_rdata !== 8'h00 || cpu_rdata !== 8'h00) $display("FAIL mid_rdata: got %h/%h want 00/00", ld_rdata, cpu_rdata); else passed++;
        total++; if (mem_en !== 1'b0 || ld_ack !== 1'b0 || cpu_stall !== 1'b1) $display("FAIL mid_outs: en=%b ack=%b stall=%b want 0/0/1", mem_en, ld_ack, cpu_stall); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (mode !== 2'(MODE_RUN)) $display("FAIL mid_mode: got %0d want %0d", mode, MODE_RUN); else passed++;
        total++; if (ld_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) $display("FAIL mid_rvalid2: got %b%b want 00", cpu_rvalid, ld_rvalid); else passed++;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        total++; if (ld_rvalid !== 1'b0 || ld_rdata !== 8'h00 || cpu_rdata !== 8'h00) $display("FAIL post_rdata: rvalid=%b %h/%h want 0 00/00", ld_rvalid, ld_rdata, cpu_rdata); else passed++;
        total++; if (cpu_stall !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'h30) $display("FAIL post_wr: stall=%b we=%b addr=%h want 0/1/30", cpu_stall, mem_we, mem_addr); else passed++;
        next_cycle();
        cpu_we = 1'b0;
        @(negedge clk);
        total++; if (cpu_stall !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0) $display("FAIL post_rd: stall=%b en=%b we=%b want 0/1/0", cpu_stall, mem_en, mem_we); else passed++;
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h77) $display("FAIL post_return: rvalid=%b data=%h want 1/77", cpu_rvalid, cpu_rdata); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b;
        next_cycle();
        for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
        for (int k = 0; k <= 256; k++) begin
            next_cycle();
            ld_req = (k < 256); ld_we = 1'b0; ld_addr = 8'(k);
            @(negedge clk);
            total++; if (ld_ack !== (k < 256)) $display("FAIL b2b_ack[%0d]: got %b", k, ld_ack); else passed++;
            if (k == 0) begin
                total++; if (ld_rvalid !== 1'b0) $display("FAIL b2b_first_rvalid: got %b want 0", ld_rvalid); else passed++;
            end else begin
                exp_b = 8'((k - 1) * 7 + 3);
                total++; if (ld_rvalid !== 1'b1 || ld_rdata !== exp_b) $display("FAIL b2b_data[%0d]: rvalid=%b data=%h want 1/%h", k - 1, ld_rvalid, ld_rdata, exp_b); else passed++;
            end
        end
        next_cycle();
        ld_req = 1'b0;
        @(negedge clk);
        total++; if (ld_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) $display("FAIL b2b_tail: got %b%b want 00", cpu_rvalid, ld_rvalid); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        test_reset();
        test_cpu_write_read();
        test_starvation();
        test_load_drain();
        test_load_exit();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
